// File: rtl/fetch_dec_exe_pipe.sv
// Three-stage fetch/decode/execute core with a 16-entry write-first register file and a HALT instruction.
// Define FDE_FORWARD_EN to compile in EX->ID forwarding; otherwise EX dependencies cost a one-cycle interlock.
module fetch_dec_exe_pipe #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              hold,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              ex_wb_valid,
  output logic [3:0]        ex_wb_rd,
  output logic [DATA_W-1:0] ex_wb_data,
  output logic [PC_W-1:0]   ex_wb_pc,
  output logic              halted,
  output logic [15:0]       bubble_cnt
);

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_ADDI = 4'd6;
  localparam logic [3:0] OP_HALT = 4'd8;

  logic [PC_W-1:0]   pc_reg;
  logic              if_id_valid_reg;
  logic [31:0]       if_id_instr_reg;
  logic [PC_W-1:0]   if_id_pc_reg;
  logic              id_ex_valid_reg;
  logic [3:0]        id_ex_op_reg;
  logic [3:0]        id_ex_rd_reg;
  logic [DATA_W-1:0] id_ex_a_reg;
  logic [DATA_W-1:0] id_ex_b_reg;
  logic [PC_W-1:0]   id_ex_pc_reg;
  logic              ex_wb_valid_reg;
  logic [3:0]        ex_wb_rd_reg;
  logic [DATA_W-1:0] ex_wb_data_reg;
  logic [PC_W-1:0]   ex_wb_pc_reg;
  logic              halted_reg;
  logic [15:0]       bubble_cnt_reg;
  logic [DATA_W-1:0] rf_mem [16];

  logic [3:0]        id_op, id_rd, id_rs1, id_rs2;
  logic [DATA_W-1:0] id_imm_ext, rs1_val, rs2_val, ex_result;
  logic              ex_hit1, ex_hit2, stall, id_writes, id_halt;

  assign id_op      = if_id_instr_reg[31:28];
  assign id_rd      = if_id_instr_reg[27:24];
  assign id_rs1     = if_id_instr_reg[23:20];
  assign id_rs2     = if_id_instr_reg[19:16];
  assign id_imm_ext = DATA_W'($signed(if_id_instr_reg[15:0]));
  assign id_writes  = if_id_valid_reg && (id_op >= OP_ADD) && (id_op <= OP_ADDI);
  assign id_halt    = if_id_valid_reg && (id_op == OP_HALT);

  assign ex_hit1 = id_ex_valid_reg && (id_ex_rd_reg != 4'd0) && (id_ex_rd_reg == id_rs1);
  assign ex_hit2 = id_ex_valid_reg && (id_ex_rd_reg != 4'd0) && (id_ex_rd_reg == id_rs2);

`ifdef FDE_FORWARD_EN
  assign stall = 1'b0;
`else
  assign stall = if_id_valid_reg && (ex_hit1 || ex_hit2);
`endif

  always_comb begin
    case (id_ex_op_reg)
      OP_ADD, OP_ADDI: ex_result = id_ex_a_reg + id_ex_b_reg;
      OP_SUB:          ex_result = id_ex_a_reg - id_ex_b_reg;
      OP_AND:          ex_result = id_ex_a_reg & id_ex_b_reg;
      OP_OR:           ex_result = id_ex_a_reg | id_ex_b_reg;
      OP_XOR:          ex_result = id_ex_a_reg ^ id_ex_b_reg;
      default:         ex_result = '0;
    endcase
  end

  // Operand priority: r0, then the EX result (newest), then the EX/WB write, then the array.
  always_comb begin
    rs1_val = rf_mem[id_rs1];
    rs2_val = rf_mem[id_rs2];
    if (ex_wb_valid_reg && ex_wb_rd_reg == id_rs1) rs1_val = ex_wb_data_reg;
    if (ex_wb_valid_reg && ex_wb_rd_reg == id_rs2) rs2_val = ex_wb_data_reg;
`ifdef FDE_FORWARD_EN
    if (ex_hit1) rs1_val = ex_result;
    if (ex_hit2) rs2_val = ex_result;
`endif
    if (id_rs1 == 4'd0) rs1_val = '0;
    if (id_rs2 == 4'd0) rs2_val = '0;
  end

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_rf
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          rf_mem[gi] <= '0;
        end else if (gi != 0 && !hold && ex_wb_valid_reg && ex_wb_rd_reg == 4'(gi)) begin
          rf_mem[gi] <= ex_wb_data_reg;
        end
      end
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_reg          <= '0;
      if_id_valid_reg <= 1'b0;
      if_id_instr_reg <= '0;
      if_id_pc_reg    <= '0;
      id_ex_valid_reg <= 1'b0;
      id_ex_op_reg    <= '0;
      id_ex_rd_reg    <= '0;
      id_ex_a_reg     <= '0;
      id_ex_b_reg     <= '0;
      id_ex_pc_reg    <= '0;
      ex_wb_valid_reg <= 1'b0;
      ex_wb_rd_reg    <= '0;
      ex_wb_data_reg  <= '0;
      ex_wb_pc_reg    <= '0;
      halted_reg      <= 1'b0;
      bubble_cnt_reg  <= '0;
    end else if (!hold) begin
      ex_wb_valid_reg <= id_ex_valid_reg;
      ex_wb_rd_reg    <= id_ex_rd_reg;
      ex_wb_data_reg  <= ex_result;
      ex_wb_pc_reg    <= id_ex_pc_reg;
      if (stall) begin
        // IF and ID keep their contents; only a bubble moves forward.
        id_ex_valid_reg <= 1'b0;
        if (bubble_cnt_reg != 16'hFFFF) bubble_cnt_reg <= bubble_cnt_reg + 16'd1;
      end else begin
        id_ex_valid_reg <= id_writes;
        id_ex_op_reg    <= id_op;
        id_ex_rd_reg    <= id_rd;
        id_ex_a_reg     <= rs1_val;
        id_ex_b_reg     <= (id_op == OP_ADDI) ? id_imm_ext : rs2_val;
        id_ex_pc_reg    <= if_id_pc_reg;
        if (id_halt) halted_reg <= 1'b1;
        if (halted_reg || id_halt) begin
          if_id_valid_reg <= 1'b0;
        end else begin
          if_id_valid_reg <= 1'b1;
          if_id_instr_reg <= imem_rdata;
          if_id_pc_reg    <= pc_reg;
          pc_reg          <= pc_reg + PC_W'(1);
        end
      end
    end
  end

  assign imem_addr   = pc_reg;
  assign ex_wb_valid = ex_wb_valid_reg;
  assign ex_wb_rd    = ex_wb_rd_reg;
  assign ex_wb_data  = ex_wb_data_reg;
  assign ex_wb_pc    = ex_wb_pc_reg;
  assign halted      = halted_reg;
  assign bubble_cnt  = bubble_cnt_reg;

endmodule

// File: tb/tb_fetch_dec_exe_pipe.sv
// Randomized and directed programs checked against an instruction-level model of fetch_dec_exe_pipe.
// The model executes the program in order and derives retirement values, timing and bubble count.
module tb_fetch_dec_exe_pipe;
  localparam int DATA_W = 32;
  localparam int PC_W   = 4;
`ifdef FDE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              hold  = 1'b0;
  logic [PC_W-1:0]   imem_addr;
  logic [31:0]       imem_rdata;
  logic              ex_wb_valid;
  logic [3:0]        ex_wb_rd;
  logic [DATA_W-1:0] ex_wb_data;
  logic [PC_W-1:0]   ex_wb_pc;
  logic              halted;
  logic [15:0]       bubble_cnt;

  logic [31:0] rom [16];
  assign imem_rdata = rom[imem_addr];

  fetch_dec_exe_pipe #(.DATA_W(DATA_W), .PC_W(PC_W)) dut (
    .clock(clock), .reset(reset), .hold(hold),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .ex_wb_valid(ex_wb_valid), .ex_wb_rd(ex_wb_rd), .ex_wb_data(ex_wb_data),
    .ex_wb_pc(ex_wb_pc), .halted(halted), .bubble_cnt(bubble_cnt)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2,
                                      input logic [15:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  // Model results
  logic [3:0]  exp_rd   [$];
  logic [31:0] exp_data [$];
  int          exp_pc   [$];
  int          exp_cyc  [$];
  int          exp_bub;
  bit          exp_halted;
  int          exp_halt_pc;
  int          addr_log [0:255];

  task automatic model_run(input int max_dyn);
    logic [31:0] regs [16];
    logic [31:0] ins, a, b, r;
    int pc, bub, prev_rd, op, rd, rs1, rs2;
    bit prev_w;
    exp_rd.delete(); exp_data.delete(); exp_pc.delete(); exp_cyc.delete();
    for (int i = 0; i < 16; i++) regs[i] = '0;
    pc = 0; bub = 0; prev_rd = 0; prev_w = 0;
    exp_halted = 0; exp_halt_pc = 0;
    for (int j = 0; j < max_dyn; j++) begin
      ins = rom[pc];
      op = int'(ins[31:28]); rd = int'(ins[27:24]);
      rs1 = int'(ins[23:20]); rs2 = int'(ins[19:16]);
      // Without forwarding, reading the previous instruction's result costs one bubble.
      if (!FWD && prev_w && prev_rd != 0 && (rs1 == prev_rd || rs2 == prev_rd)) bub++;
      if (op == 8) begin
        exp_halted = 1; exp_halt_pc = pc;
        break;
      end
      prev_w = (op >= 1 && op <= 6);
      if (prev_w) begin
        a = regs[rs1];
        b = (op == 6) ? {{16{ins[15]}}, ins[15:0]} : regs[rs2];
        case (op)
          1, 6:    r = a + b;
          2:       r = a - b;
          3:       r = a & b;
          4:       r = a | b;
          default: r = a ^ b;
        endcase
        exp_rd.push_back(4'(rd)); exp_data.push_back(r);
        exp_pc.push_back(pc); exp_cyc.push_back(3 + j + bub);
        if (rd != 0) regs[rd] = r;
        prev_rd = rd;
      end
      pc = (pc + 1) % 16;
    end
    exp_bub = bub;
  endtask

  function automatic logic [60:0] snap_now();
    return {imem_addr, ex_wb_valid, ex_wb_rd, ex_wb_data, ex_wb_pc, bubble_cnt};
  endfunction

  // mode 0: no hold (cycle-exact timing), 1: random hold, 2: hold on cycles 5..7
  task automatic run_prog(input string name, input int ncyc, input int mode);
    int k, exp_n;
    logic hold_now;
    logic [60:0] prev, cur;
    model_run(ncyc);
    @(negedge clock);
    #2 reset = 1'b0; hold = 1'b0;
    #1 check_eq({name, "_rst_async"}, {snap_now(), halted}, '0);
    repeat (2) @(negedge clock);
    #1 check_eq({name, "_rst_low"}, {snap_now(), halted}, '0);
    reset = 1'b1;
    #1 addr_log[0] = int'(imem_addr);
    check_eq({name, "_first_fetch"}, imem_addr, 0);
    prev = snap_now();
    k = 0;
    for (int c = 1; c <= ncyc; c++) begin
      hold_now = (mode == 1) ? ($urandom_range(0, 3) == 0) : (mode == 2) ? (c >= 5 && c <= 7) : 1'b0;
      hold = hold_now;
      @(negedge clock);
      #1 cur = snap_now();
      addr_log[c] = int'(imem_addr);
      if (hold_now) begin
        check_eq({name, "_hold_freeze"}, cur, prev);
      end else if (ex_wb_valid) begin
        $display("%s cyc=%0d retire pc=%0d rd=%0d data=%08h", name, c, ex_wb_pc, ex_wb_rd, ex_wb_data);
        if (k < exp_rd.size()) begin
          check_eq({name, "_ret_rd"}, ex_wb_rd, exp_rd[k]);
          check_eq({name, "_ret_data"}, ex_wb_data, exp_data[k]);
          check_eq({name, "_ret_pc"}, ex_wb_pc, exp_pc[k]);
          if (mode == 0) check_eq({name, "_ret_cycle"}, c, exp_cyc[k]);
        end
        k++;
      end
      prev = cur;
    end
    hold = 1'b0;
    exp_n = 0;
    for (int i = 0; i < exp_cyc.size(); i++)
      if (mode != 0 || exp_cyc[i] <= ncyc) exp_n++;
    check_eq({name, "_ret_count"}, k, exp_n);
    check_eq({name, "_halted"}, halted, exp_halted);
    if (exp_halted) begin
      check_eq({name, "_halt_addr"}, imem_addr, (exp_halt_pc + 1) % 16);
      check_eq({name, "_bubbles"}, bubble_cnt, exp_bub);
    end
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 16; i++) rom[i] = enc(4'd0, 4'd0, 4'd0, 4'd0, 16'd0);
  endtask

  task automatic load_chain();
    fill_nop();
    rom[0] = enc(4'd6, 4'd1, 4'd0, 4'd0, 16'd5);
    rom[1] = enc(4'd6, 4'd2, 4'd0, 4'd0, 16'd3);
    rom[2] = enc(4'd1, 4'd3, 4'd1, 4'd2, 16'd0);
    rom[3] = enc(4'd2, 4'd4, 4'd3, 4'd1, 16'd0);
    rom[4] = enc(4'd8, 4'd0, 4'd0, 4'd0, 16'd0);
  endtask

  initial begin
    int r;
    logic [3:0] op;
    fill_nop();

    load_chain();
    run_prog("chain", 30, 0);
    check_eq("chain_r3", exp_data[2], 32'd8);
    check_eq("chain_bubcnt", bubble_cnt, FWD ? 0 : 2);

    run_prog("chain_hold", 30, 2);
    check_eq("chain_hold_bubcnt", bubble_cnt, FWD ? 0 : 2);

    fill_nop();
    rom[0] = enc(4'd6, 4'd0, 4'd0, 4'd0, 16'd7);
    rom[1] = enc(4'd1, 4'd5, 4'd0, 4'd0, 16'd0);
    rom[2] = enc(4'd6, 4'd6, 4'd0, 4'd0, 16'hFFFF);
    rom[3] = enc(4'd6, 4'd6, 4'd6, 4'd0, 16'd1);
    rom[4] = enc(4'd8, 4'd0, 4'd0, 4'd0, 16'd0);
    run_prog("r0_wrap", 30, 0);

    fill_nop();
    rom[0] = enc(4'd6, 4'd1, 4'd0, 4'd0, 16'd1);
    rom[1] = enc(4'd8, 4'd0, 4'd0, 4'd0, 16'd0);
    rom[2] = enc(4'd6, 4'd2, 4'd0, 4'd0, 16'd9);
    for (int i = 3; i < 16; i++) rom[i] = enc(4'd6, 4'd3, 4'd0, 4'd0, 16'(i));
    run_prog("halt", 40, 0);
    check_eq("halt_freeze_addr", imem_addr, 2);

    fill_nop();
    rom[15] = enc(4'd6, 4'd7, 4'd0, 4'd0, 16'd2);
    run_prog("pc_wrap", 25, 0);
    check_eq("pc_wrap_a15", addr_log[15], 15);
    check_eq("pc_wrap_a16", addr_log[16], 0);

    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 15; i++) begin
        r = int'($urandom_range(0, 99));
        op = (r < 4) ? 4'd8 : (r < 75) ? 4'($urandom_range(1, 6)) : 4'($urandom_range(0, 15));
        rom[i] = enc(op, 4'($urandom_range(0, 4)), 4'($urandom_range(0, 4)),
                     4'($urandom_range(0, 4)), 16'($urandom));
      end
      rom[15] = enc(4'd8, 4'd0, 4'd0, 4'd0, 16'd0);
      run_prog($sformatf("rand%0d", t), 150, t % 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_dec_exe_pipe.md
# fetch_dec_exe_pipe

Parametrised three-stage fetch/decode/execute pipeline core that supersedes the fixed-width fetchDecExe. It fetches 32-bit instructions from an external asynchronous instruction ROM and decodes them against a 16-entry register file. It executes simple ALU operations and presents the EX/WB pipeline register on output ports for writeback observation and bench checking. It adds data width and PC width parameters, a global hold, a HALT instruction, operand hazard handling, and a bubble counter.

## Interface
- `DATA_W`, 32: register/ALU width; legal values are 16 or more.
- `PC_W`, 8: PC / instruction address width (word addresses).
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `hold`  in  1  freezes PC, all pipeline registers, register-file write and the bubble counter while high.
- `imem_addr`  out  PC_W  equals `pc`, combinational from the PC register.
- `imem_rdata`  in  32  instruction at `imem_addr`, valid in the same cycle.
- `ex_wb_valid`  out  1  the EX/WB register holds a retiring instruction.
- `ex_wb_rd`  out  4  destination register.
- `ex_wb_data`  out  DATA_W  result.
- `ex_wb_pc`  out  PC_W  PC of the retiring instruction.
- `halted`  out  1  a HALT instruction has passed decode; sticky until reset.
- `bubble_cnt`  out  16  number of interlock bubbles inserted; saturates at 16'hFFFF.

## Operation
- Instruction format: opcode[31:28], rd[27:24], rs1[23:20], rs2[19:16], imm[15:0].
- Opcodes:
  - 0 NOP
  - 1 ADD
  - 2 SUB (rs1-rs2)
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 ADDI (rs1 + sign-extended imm)
  - 8 HALT
  - all others execute as NOP
- NOP and HALT produce `ex_wb_valid`=0.
- Arithmetic wraps modulo 2^DATA_W. The PC increments by 1 and wraps modulo 2^PC_W.
- Register file:
  - 16 x DATA_W; r0 always reads 0 and writes to it are discarded.
  - Written from EX/WB when `ex_wb_valid` && !`hold`.
  - Write-first: a decode read of the register being written this cycle returns the new value.
- Stages:
  - IF: latch `imem_rdata` and `pc` into IF/ID.
  - ID: decode, read operands, latch into ID/EX.
  - EX: ALU, latch into EX/WB.
- RAW hazard on an instruction in EX (valid, rd≠0, rd matches rs1 or rs2 of the instruction in ID):
  - With `FDE_FORWARD_EN` defined, the EX ALU result is forwarded into ID; no stall.
  - Otherwise ID and IF hold for one cycle, a bubble (valid=0) enters ID/EX, and `bubble_cnt` increments.
- Hazards against EX/WB are always resolved by the write-first register file.
- HALT in ID:
  - `halted` is set at the next edge.
  - The PC freezes from that edge onward, and IF/ID is invalidated so the instruction behind HALT is squashed.
  - Instructions already in ID/EX and EX/WB drain normally.
- `hold` has priority over every other event, including the interlock and HALT.

## Timing
- Reset values:
  - `pc`=0 (so `imem_addr`=0).
  - All stage valid bits 0, so `ex_wb_valid`=0.
  - `ex_wb_rd`=0, `ex_wb_data`=0, `ex_wb_pc`=0.
  - `halted`=0, `bubble_cnt`=0, and all registers 0.
- Latency:
  - An instruction presented on `imem_rdata` in cycle t appears on the `ex_wb_*` outputs after the 3rd rising edge (t+3).
  - Its register is written at the 4th edge.
- Throughput: one instruction per cycle when there is no hold and no interlock.
- Reset mid-operation:
  - Asserting `reset` clears all state immediately and asynchronously; in-flight instructions are lost.
  - Fetch restarts at PC 0 on the first edge after deassertion.
- Hold and interlock together: `hold` wins, and the interlock bubble is inserted (and counted once) on the first unheld cycle.
- When `bubble_cnt` is at 16'hFFFF, further bubbles leave it unchanged.

## Configuration
- `FDE_FORWARD_EN` defined: EX→ID forwarding path compiled in; no interlocks occur and `bubble_cnt` stays 0.
- `FDE_FORWARD_EN` undefined: no forwarding mux; a one-cycle interlock per EX dependency.

## Test plan
- Reset: hold `reset`=0 for 2 cycles mid-stream, then release. Required: all outputs at their reset values while low; first fetch is from `imem_addr`=0.
- Dependent ALU chain: program ADDI r1,r0,5; ADDI r2,r0,3; ADD r3,r1,r2; SUB r4,r3,r1. Required `ex_wb` retirements: r1=5, r2=3, r3=8, r4=3.
  - With `FDE_FORWARD_EN`: retirements on 4 consecutive cycles, `bubble_cnt`=0.
  - Without it: 2 bubbles, `bubble_cnt`=2.
- r0 and wrap-around:
  - ADDI r0,r0,7 then ADD r5,r0,r0 → r5=0.
  - ADDI r6,r0,-1 then ADDI r6,r6,1 → r6=0 (DATA_W=32).
- HALT: program ADDI r1,r0,1; HALT; ADDI r2,r0,9. Required:
  - r1 retires.
  - `halted`=1 and stays 1.
  - r2 never retires.
  - `imem_addr` freezes at 2.
- Hold: assert `hold` for 3 cycles during the dependent ALU chain. Required:
  - `pc`, `ex_wb_*` and `bubble_cnt` are unchanged during hold.
  - Final register values match the no-hold run.
- PC wrap: with PC_W=4, NOPs at 0..14 and ADDI r7,r0,2 at address 15. Required: `imem_addr` goes 15→0, and r7=2 retires with `ex_wb_pc`=15.
